banked_stack_address_unit: RTL
==============================

Name: banked_stack_address_unit

Overview:
- Sequential successor to the combinational memory address handler.
- Holds the PC and two banked stack pointers (privileged/user) in registers, and executes multi-word PUSH/POP bursts one memory beat per cycle.
- Detects stack overflow and underflow, and passes data addresses through when no burst is running.
- Sits between the control unit and the data/instruction memory address ports.

Parameters:
- ADDR_WIDTH, 14, memory address width.
- DATA_WIDTH, 32, width of PC, SP and input_address.
- CODE_AREA_SIZE, 4096, words below the privileged stack region.
- PRIV_STACK_SIZE, 2048, privileged stack words; region [CODE_AREA_SIZE, CODE_AREA_SIZE+PRIV_STACK_SIZE-1].
- USER_STACK_SIZE, 2048, user stack words; region directly above the privileged region.
- BURST_WIDTH, 4, width of op_count; maximum burst is 2^BURST_WIDTH-1 words.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- privilege_mode_flag, input, 1, 1 = privileged bank, 0 = user bank; sampled at op accept.
- op, input, 2, 1 = PUSH, 2 = POP, 0/3 = none.
- op_valid, input, 1, request qualifier.
- op_count, input, BURST_WIDTH, number of words in the burst.
- op_ready, output, 1, unit can accept an op.
- input_address, input, DATA_WIDTH, data address for non-stack accesses.
- mem_address, output, ADDR_WIDTH, data memory address.
- mem_valid, output, 1, a stack beat is presented this cycle.
- mem_last, output, 1, final beat of the burst.
- fault, output, 1, one-cycle fault pulse.
- fault_code, output, 2, 1 = overflow, 2 = underflow, 0 = none.
- sp_priv, output, DATA_WIDTH, privileged SP register.
- sp_user, output, DATA_WIDTH, user SP register.
- pc_advance, input, 1, increment PC.
- pc_load, input, 1, load PC.
- pc_load_value, input, DATA_WIDTH, value for pc_load.
- pc, output, DATA_WIDTH, PC register.
- instruction_address, output, ADDR_WIDTH, pc[ADDR_WIDTH-1:0].

Behaviour:
- **Reset** (reset==0 at a clock edge):
  - FSM → IDLE.
  - sp_priv = sp_user = all-ones (EMPTY sentinel).
  - pc = RESET_VECTOR.
  - fault = 0, fault_code = 0, mem_valid = 0, mem_last = 0, op_ready = 1 from the next cycle.
  - Reset mid-burst abandons the remaining beats with no fault.
- **Regions:** per bank, TOP = lowest address, BOTTOM = highest address. Stacks grow downward.
- **FSM states:** IDLE, PUSH, POP.
  - op_ready = 1 only in IDLE.
  - Accept when op_valid & op_ready & op ∈ {1,2}; latch op_count, the bank, and the direction.
  - op_count == 0: accept is a no-op; stay IDLE, no beat, no fault.
  - Otherwise go to PUSH/POP; beats occupy cycles 1..N after accept.
  - mem_last is asserted on beat N, then the FSM returns to IDLE.
  - A mode change mid-burst is ignored.
- **PUSH beat** (selected bank SP = S):
  - S == EMPTY → address = BOTTOM.
  - S > TOP → address = S-1.
  - S == TOP (full) → no beat: mem_valid = 0, fault = 1, fault_code = 1, SP unchanged, FSM → IDLE.
  - On a valid beat: mem_address = the new SP (combinational from the SP register), mem_valid = 1, SP ← address at the clock edge.
- **POP beat:**
  - S == EMPTY → underflow: fault = 1, fault_code = 2, no beat, FSM → IDLE.
  - Otherwise mem_address = S, mem_valid = 1.
  - SP ← S+1 if S < BOTTOM, else SP ← EMPTY.
- **Fault:** only the faulting beat and the beats after it are dropped. Earlier beats of the same burst remain committed.
- **Outside beats:** mem_address = input_address[ADDR_WIDTH-1:0], mem_valid = 0.
- **Bank isolation:** the non-selected bank's SP is never modified.
- **PC:**
  - pc_load has priority over pc_advance.
  - Advance: pc ← pc+1, modulo 2^DATA_WIDTH (0xFFFFFFFF wraps to 0).
  - PC updates are independent of FSM state.
- **Arithmetic:** all SP/PC arithmetic is DATA_WIDTH unsigned. Region bounds are computed from parameters at elaboration.

Test Plan:
- Reset, then privileged push with count 1 → cycle 1: mem_address = 6143, mem_valid = 1, mem_last = 1; afterwards sp_priv = 6143, sp_user = 0xFFFFFFFF.
- User push with count 3 from empty → beats 8191, 8190, 8189 on consecutive cycles, mem_last on 8189; sp_user = 8189; op_ready = 0 during the beats.
- User pop with count 3 from sp_user = 8189 → beats 8189, 8190, 8191; sp_user = 0xFFFFFFFF. Then pop with count 1 → fault = 1, fault_code = 2, mem_valid = 0.
- Fill the privileged bank with 2048 pushes (sp_priv = 4096), then push with count 2 → no beat, fault_code = 1 pulse, sp_priv stays 4096, op_ready = 1 on the next cycle.
- After reset, pc = 0. Three cycles of pc_advance → pc = 3. pc_load = 0x100 together with pc_advance → pc = 0x100, instruction_address = 0x100.
- Start a 4-word push, assert reset == 0 after beat 2 → next cycle: FSM IDLE, both SPs = 0xFFFFFFFF, mem_valid = 0, fault = 0.

Source files
------------

// File: rtl/banked_stack_address_unit_if.sv
// Bus between the control unit (master) and the banked stack address unit (slave).
//
// Handshake: an op is transferred on a rising clock edge where op_valid and
// op_ready are both 1. The master holds op/op_count/privilege_mode_flag stable
// while op_valid is high. op_ready is high only while the unit is idle, so at
// most one burst is in flight. Memory beats carry no back-pressure: a beat is
// presented for exactly one cycle whenever mem_valid is 1.
interface banked_stack_address_unit_if #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 4
);
  logic                   privilege_mode_flag;
  logic [1:0]             op;
  logic                   op_valid;
  logic [BURST_WIDTH-1:0] op_count;
  logic                   op_ready;
  logic [DATA_WIDTH-1:0]  input_address;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic                   mem_valid;
  logic                   mem_last;
  logic                   fault;
  logic [1:0]             fault_code;
  logic [DATA_WIDTH-1:0]  sp_priv;
  logic [DATA_WIDTH-1:0]  sp_user;
  logic                   pc_advance;
  logic                   pc_load;
  logic [DATA_WIDTH-1:0]  pc_load_value;
  logic [DATA_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  instruction_address;

  modport master (
    output privilege_mode_flag, op, op_valid, op_count, input_address,
           pc_advance, pc_load, pc_load_value,
    input  op_ready, mem_address, mem_valid, mem_last, fault, fault_code,
           sp_priv, sp_user, pc, instruction_address
  );

  modport slave (
    input  privilege_mode_flag, op, op_valid, op_count, input_address,
           pc_advance, pc_load, pc_load_value,
    output op_ready, mem_address, mem_valid, mem_last, fault, fault_code,
           sp_priv, sp_user, pc, instruction_address
  );
endinterface

// File: rtl/banked_stack_address_unit.sv
// Banked stack address unit: PC register plus privileged/user stack pointers.
// Executes PUSH/POP bursts one memory beat per cycle, flags overflow and
// underflow, and passes input_address through when no beat is active.
module banked_stack_address_unit #(
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_WIDTH      = 32,
  parameter int CODE_AREA_SIZE  = 4096,
  parameter int PRIV_STACK_SIZE = 2048,
  parameter int USER_STACK_SIZE = 2048,
  parameter int BURST_WIDTH     = 4,
  parameter int RESET_VECTOR    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  banked_stack_address_unit_if.slave bus,
  output logic [1:0]                 state_dbg
);
  // Stacks grow downward: TOP is the lowest word of a bank, BOTTOM the highest.
  localparam logic [DATA_WIDTH-1:0] EMPTY    = '1;
  localparam logic [DATA_WIDTH-1:0] PRIV_TOP = DATA_WIDTH'(CODE_AREA_SIZE);
  localparam logic [DATA_WIDTH-1:0] PRIV_BOT = DATA_WIDTH'(CODE_AREA_SIZE + PRIV_STACK_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] USER_TOP = DATA_WIDTH'(CODE_AREA_SIZE + PRIV_STACK_SIZE);
  localparam logic [DATA_WIDTH-1:0] USER_BOT = DATA_WIDTH'(CODE_AREA_SIZE + PRIV_STACK_SIZE
                                                           + USER_STACK_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_VECTOR);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_POP  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   bank_q, bank_d;   // 1 = privileged bank
  logic [DATA_WIDTH-1:0]  sp_priv_q, sp_priv_d;
  logic [DATA_WIDTH-1:0]  sp_user_q, sp_user_d;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;

  logic [DATA_WIDTH-1:0]  cur_sp, top, bottom, beat_addr, next_sp;
  logic                   beat, flt;
  logic [1:0]             flt_code;
  logic                   accept;

  // Decide what the current burst cycle does from the selected bank's SP.
  always_comb begin
    cur_sp    = bank_q ? sp_priv_q : sp_user_q;
    top       = bank_q ? PRIV_TOP : USER_TOP;
    bottom    = bank_q ? PRIV_BOT : USER_BOT;
    beat      = 1'b0;
    flt       = 1'b0;
    flt_code  = 2'd0;
    beat_addr = cur_sp;
    next_sp   = cur_sp;
    case (state_q)
      ST_PUSH: begin
        if (cur_sp == EMPTY) begin
          beat      = 1'b1;
          beat_addr = bottom;
          next_sp   = bottom;
        end else if (cur_sp > top) begin
          beat      = 1'b1;
          beat_addr = cur_sp - 1'b1;
          next_sp   = cur_sp - 1'b1;
        end else begin
          flt      = 1'b1;
          flt_code = 2'd1;
        end
      end
      ST_POP: begin
        if (cur_sp == EMPTY) begin
          flt      = 1'b1;
          flt_code = 2'd2;
        end else begin
          beat      = 1'b1;
          beat_addr = cur_sp;
          next_sp   = (cur_sp < bottom) ? cur_sp + 1'b1 : EMPTY;
        end
      end
      default: ;
    endcase
  end

  // Zero-length bursts are accepted but never leave IDLE.
  assign accept = (state_q == ST_IDLE) && bus.op_valid
                  && ((bus.op == 2'd1) || (bus.op == 2'd2))
                  && (bus.op_count != '0);

  // Next-state for the burst FSM and both stack pointers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    sp_priv_d = sp_priv_q;
    sp_user_d = sp_user_q;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = (bus.op == 2'd1) ? ST_PUSH : ST_POP;
        cnt_d   = bus.op_count;
        bank_d  = bus.privilege_mode_flag;
      end
    end else if (flt) begin
      state_d = ST_IDLE;
    end else if (beat) begin
      if (bank_q) sp_priv_d = next_sp;
      else        sp_user_d = next_sp;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == BURST_WIDTH'(1)) state_d = ST_IDLE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // PC next value: load wins over advance; advance wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (bus.pc_load)         pc_d = bus.pc_load_value;
    else if (bus.pc_advance) pc_d = pc_q + 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bank_q    <= 1'b0;
      sp_priv_q <= EMPTY;
      sp_user_q <= EMPTY;
      pc_q      <= RESET_PC;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      sp_priv_q <= sp_priv_d;
      sp_user_q <= sp_user_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.op_ready            = (state_q == ST_IDLE);
  assign bus.mem_valid           = beat;
  assign bus.mem_last            = beat && (cnt_q == BURST_WIDTH'(1));
  assign bus.mem_address         = beat ? beat_addr[ADDR_WIDTH-1:0]
                                        : bus.input_address[ADDR_WIDTH-1:0];
  assign bus.fault               = flt;
  assign bus.fault_code          = flt_code;
  assign bus.sp_priv             = sp_priv_q;
  assign bus.sp_user             = sp_user_q;
  assign bus.pc                  = pc_q;
  assign bus.instruction_address = pc_q[ADDR_WIDTH-1:0];
  assign state_dbg               = state_q;

  // Upper address bits are intentionally dropped on the memory ports.
  logic unused_high_bits;
  assign unused_high_bits = ^{bus.input_address[DATA_WIDTH-1:ADDR_WIDTH],
                              beat_addr[DATA_WIDTH-1:ADDR_WIDTH]};
endmodule
